wb_sequencer: RTL and testbench

Write-back sequencer for the Y86 sequential core. It takes one retiring instruction per handshake from the execute/memory stages and works out its register destinations (dstE, dstM). It then drives the single-write-port register file over one or two cycles: two cycles for popq, which writes both %rsp and rA. It also tracks halt/invalid status and counts retired instructions.

---
 rtl/wb_sequencer.sv | 161 ++++++++++++++++
 tb/tb_wb_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Purpose : Y86 write-back sequencer; derives dstE/dstM and drives a single-write-port register file.
// Latency : accept at edge N -> E write in cycle N+1, M write (popq) in cycle N+2; wb_done on the last write cycle.
// Backpr. : wb_ready high only in IDLE; wb_valid held while busy is ignored and nothing is captured.
//
// Ports: clk/rst_n (sync active-low); wb_valid/wb_ready handshake with icode, rA, rB, cnd, valE, valM;
//        rf_we/rf_waddr/rf_wdata register-file write port; wb_done completion pulse;
//        halted/stat_ins sticky status; retired completed-instruction counter.
module wb_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic             wb_done,
    output logic             halted,
    output logic             stat_ins,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR_E = 2'd1,
        S_WR_M = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        dst_e_q, dst_e_d;
    logic [3:0]        dst_m_q, dst_m_d;
    logic [63:0]       val_e_q, val_e_d;
    logic [63:0]       val_m_q, val_m_d;
    logic              halt_pulse_q, halt_pulse_d;
    logic              halted_q, halted_d;
    logic              stat_ins_q, stat_ins_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // Destination decode from the live inputs; only used at the accept edge.
    logic [3:0] dst_e_in, dst_m_in;

    always_comb begin
        dst_e_in = RNONE;
        dst_m_in = RNONE;
        case (icode)
            4'h2:                      dst_e_in = cnd ? rB : RNONE;
            4'h3, 4'h6:                dst_e_in = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e_in = RSP;
            default:                   dst_e_in = RNONE;
        endcase
        if (icode == 4'h5 || icode == 4'hB) begin
            dst_m_in = rA;
        end
    end

    always_comb begin
        state_d      = state_q;
        dst_e_d      = dst_e_q;
        dst_m_d      = dst_m_q;
        val_e_d      = val_e_q;
        val_m_d      = val_m_q;
        halt_pulse_d = 1'b0;
        halted_d     = halted_q;
        stat_ins_d   = stat_ins_q;
        wb_ready     = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = RNONE;
        rf_wdata     = 64'd0;
        // halt/invalid completes in the cycle right after it was accepted
        wb_done      = halt_pulse_q;

        case (state_q)
            S_IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    dst_e_d = dst_e_in;
                    dst_m_d = dst_m_in;
                    val_e_d = valE;
                    val_m_d = valM;
                    if (icode >= 4'h1 && icode <= 4'hB) begin
                        state_d = S_WR_E;
                    end else begin
                        state_d      = S_HALT;
                        halted_d     = 1'b1;
                        stat_ins_d   = (icode > 4'hB);
                        halt_pulse_d = 1'b1;
                    end
                end
            end
            S_WR_E: begin
                if (dst_e_q != RNONE) begin
                    rf_we    = 1'b1;
                    rf_waddr = dst_e_q;
                    rf_wdata = val_e_q;
                end
                if (dst_m_q != RNONE) begin
                    state_d = S_WR_M;
                end else begin
                    wb_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_M: begin
                // M write lands after E, so popq %rsp leaves %rsp = valM
                rf_we    = 1'b1;
                rf_waddr = dst_m_q;
                rf_wdata = val_m_q;
                wb_done  = 1'b1;
                state_d  = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        retired_d = retired_q + CNT_W'(wb_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dst_e_q      <= RNONE;
            dst_m_q      <= RNONE;
            val_e_q      <= 64'd0;
            val_m_q      <= 64'd0;
            halt_pulse_q <= 1'b0;
            halted_q     <= 1'b0;
            stat_ins_q   <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            dst_e_q      <= dst_e_d;
            dst_m_q      <= dst_m_d;
            val_e_q      <= val_e_d;
            val_m_q      <= val_m_d;
            halt_pulse_q <= halt_pulse_d;
            halted_q     <= halted_d;
            stat_ins_q   <= stat_ins_d;
            retired_q    <= retired_d;
        end
    end

    assign halted   = halted_q;
    assign stat_ins = stat_ins_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        wb_done;
    logic        halted;
    logic        stat_ins;
    logic [31:0] retired;

    int n_vec = 0;
    int n_bad = 0;

    wb_sequencer #(.CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wb_done  (wb_done),
        .halted   (halted),
        .stat_ins (stat_ins),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, ".we"},    {63'd0, rf_we},    64'd0);
        chk({tag, ".waddr"}, {60'd0, rf_waddr}, 64'hF);
        chk({tag, ".wdata"}, rf_wdata,          64'd0);
    endtask

    task automatic present(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                           input logic c, input logic [63:0] e, input logic [63:0] m);
        wb_valid = 1'b1;
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wb_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0;
        icode = 4'h0; rA = 4'h0; rB = 4'h0; cnd = 1'b0; valE = 64'd0; valM = 64'd0;
        do_reset();

        // reset state
        chk("rst.ready",   {63'd0, wb_ready}, 64'd1);
        chk_idle_out("rst");
        chk("rst.done",    {63'd0, wb_done},  64'd0);
        chk("rst.halted",  {63'd0, halted},   64'd0);
        chk("rst.statins", {63'd0, stat_ins}, 64'd0);
        chk("rst.retired", {32'd0, retired},  64'd0);

        // irmovq $216, %rbx
        present(4'h3, 4'hF, 4'h3, 1'b0, 64'd216, 64'd0);
        step(); wb_valid = 1'b0;
        chk("irm.we",    {63'd0, rf_we},    64'd1);
        chk("irm.waddr", {60'd0, rf_waddr}, 64'd3);
        chk("irm.wdata", rf_wdata,          64'd216);
        chk("irm.done",  {63'd0, wb_done},  64'd1);
        chk("irm.ready", {63'd0, wb_ready}, 64'd0);
        step();
        chk("irm.ready2", {63'd0, wb_ready}, 64'd1);
        chk("irm.retired", {32'd0, retired}, 64'd1);
        chk_idle_out("irm.after");

        // cmovXX not taken
        present(4'h2, 4'h1, 4'h2, 1'b0, 64'd512, 64'd0);
        step(); wb_valid = 1'b0;
        chk_idle_out("cmov0");
        chk("cmov0.done", {63'd0, wb_done}, 64'd1);
        step();
        chk("cmov0.retired", {32'd0, retired}, 64'd2);

        // cmovXX taken
        present(4'h2, 4'h1, 4'h2, 1'b1, 64'd512, 64'd0);
        step(); wb_valid = 1'b0;
        chk("cmov1.we",    {63'd0, rf_we},    64'd1);
        chk("cmov1.waddr", {60'd0, rf_waddr}, 64'd2);
        chk("cmov1.wdata", rf_wdata,          64'd512);
        chk("cmov1.done",  {63'd0, wb_done},  64'd1);
        step();
        chk("cmov1.retired", {32'd0, retired}, 64'd3);

        // popq %rdx; inputs scrambled while busy must not matter
        present(4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'h55);
        step(); wb_valid = 1'b0;
        icode = 4'h3; rA = 4'h7; rB = 4'h9; valE = 64'hDEAD; valM = 64'hAA;
        chk("pop.e.we",    {63'd0, rf_we},    64'd1);
        chk("pop.e.waddr", {60'd0, rf_waddr}, 64'd4);
        chk("pop.e.wdata", rf_wdata,          64'h108);
        chk("pop.e.done",  {63'd0, wb_done},  64'd0);
        chk("pop.e.ready", {63'd0, wb_ready}, 64'd0);
        step();
        chk("pop.m.we",    {63'd0, rf_we},    64'd1);
        chk("pop.m.waddr", {60'd0, rf_waddr}, 64'd2);
        chk("pop.m.wdata", rf_wdata,          64'h55);
        chk("pop.m.done",  {63'd0, wb_done},  64'd1);
        chk("pop.m.ready", {63'd0, wb_ready}, 64'd0);
        step();
        chk("pop.ready", {63'd0, wb_ready}, 64'd1);
        chk("pop.retired", {32'd0, retired}, 64'd4);

        // popq %rsp with wb_valid held high through both busy cycles
        present(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55);
        step();
        chk("poprsp.e.waddr", {60'd0, rf_waddr}, 64'd4);
        chk("poprsp.e.wdata", rf_wdata,          64'h108);
        step();
        chk("poprsp.m.waddr", {60'd0, rf_waddr}, 64'd4);
        chk("poprsp.m.wdata", rf_wdata,          64'h55);
        chk("poprsp.m.done",  {63'd0, wb_done},  64'd1);
        wb_valid = 1'b0;
        step();
        chk("poprsp.ready", {63'd0, wb_ready}, 64'd1);
        chk_idle_out("poprsp.after");
        chk("poprsp.retired", {32'd0, retired}, 64'd5);

        // reset in the middle of popq: E cycle visible, then reset drops the M write
        present(4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'h55);
        step(); wb_valid = 1'b0;
        chk("rstmid.e.we", {63'd0, rf_we}, 64'd1);
        rst_n = 1'b0;
        step();
        chk_idle_out("rstmid");
        chk("rstmid.done",    {63'd0, wb_done},  64'd0);
        chk("rstmid.ready",   {63'd0, wb_ready}, 64'd1);
        chk("rstmid.retired", {32'd0, retired},  64'd0);
        rst_n = 1'b1;
        step();
        chk("rstmid.done2",    {63'd0, wb_done}, 64'd0);
        chk("rstmid.retired2", {32'd0, retired}, 64'd0);

        // halt
        present(4'h0, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0);
        step(); wb_valid = 1'b0;
        chk("halt.done",    {63'd0, wb_done},  64'd1);
        chk("halt.halted",  {63'd0, halted},   64'd1);
        chk("halt.statins", {63'd0, stat_ins}, 64'd0);
        chk("halt.ready",   {63'd0, wb_ready}, 64'd0);
        chk_idle_out("halt");
        step();
        chk("halt.done2",   {63'd0, wb_done},  64'd0);
        chk("halt.retired", {32'd0, retired},  64'd1);
        present(4'h3, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0);
        step();
        step();
        wb_valid = 1'b0;
        chk_idle_out("halt.ignore");
        chk("halt.ignore.ready",   {63'd0, wb_ready}, 64'd0);
        chk("halt.ignore.retired", {32'd0, retired},  64'd1);

        // invalid icode after reset
        do_reset();
        present(4'hC, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0);
        step(); wb_valid = 1'b0;
        chk("ins.done",    {63'd0, wb_done},  64'd1);
        chk("ins.halted",  {63'd0, halted},   64'd1);
        chk("ins.statins", {63'd0, stat_ins}, 64'd1);
        chk("ins.ready",   {63'd0, wb_ready}, 64'd0);
        step();
        chk("ins.retired", {32'd0, retired},  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
